// File: rtl/cfs_fifo_unpacker_if.sv
// Handshake bundle for the FIFO width down-converter: word input side, slice output side.
// master = producer/consumer environment, slave = the unpacker itself.
interface cfs_fifo_unpacker_if #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
);
   logic                 in_valid;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 in_ready;
   logic                 msb_first;
   logic                 out_valid;
   logic [OUT_WIDTH-1:0] out_data;
   logic                 out_ready;
   logic                 out_last;
   logic                 busy;

   modport master (
      output in_valid, in_data, msb_first, out_ready,
      input  in_ready, out_valid, out_data, out_last, busy
   );

   modport slave (
      input  in_valid, in_data, msb_first, out_ready,
      output in_ready, out_valid, out_data, out_last, busy
   );
endinterface

// File: rtl/cfs_fifo_unpacker.sv
// Width down-converter: holds one IN_WIDTH word and emits it as RATIO OUT_WIDTH slices,
// one per cycle, reloading on the last slice so consecutive words have no bubble.
module cfs_fifo_unpacker #(
   parameter int IN_WIDTH  = 32,
   parameter int OUT_WIDTH = 8
) (
   input logic                clk,
   input logic                reset_n,
   cfs_fifo_unpacker_if.slave bus
);
   localparam int OW_SAFE   = (OUT_WIDTH < 1) ? 1 : OUT_WIDTH;
   localparam int RATIO     = (IN_WIDTH / OW_SAFE < 1) ? 1 : IN_WIDTH / OW_SAFE;
   localparam int IDX_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(RATIO - 1);

   if (IN_WIDTH < 1 || OUT_WIDTH < 1 || (IN_WIDTH % OW_SAFE) != 0) begin : g_bad_params
      $error("cfs_fifo_unpacker: IN_WIDTH must be a nonzero multiple of OUT_WIDTH");
   end

   typedef enum logic {EMPTY = 1'b0, SEND = 1'b1} state_e;

   state_e                          state_q, state_d;
   logic [IN_WIDTH-1:0]             word_q, word_d;
   logic [IDX_WIDTH-1:0]            idx_q, idx_d;
   logic                            order_q, order_d;
   logic                            full_q;
   logic [RATIO-1:0][OUT_WIDTH-1:0] slices;
   logic [IDX_WIDTH-1:0]            sel;
   logic [OUT_WIDTH-1:0]            slice_data;
   logic                            last;
   logic                            accept;
   logic                            slice_hs;

   assign full_q = (state_q == SEND);
   assign slices = word_q;
   assign sel    = order_q ? (LAST_IDX - idx_q) : idx_q;
   assign last   = full_q & (idx_q == LAST_IDX);

   // Mux loop rather than a variable index keeps the select width-clean for any RATIO.
   always_comb begin
      slice_data = '0;
      for (int i = 0; i < RATIO; i++) begin
         if (full_q && sel == IDX_WIDTH'(i)) slice_data = slices[i];
      end
   end

   assign bus.out_valid = full_q;
   assign bus.busy      = full_q;
   assign bus.out_last  = last;
   assign bus.out_data  = slice_data;
   assign bus.in_ready  = reset_n & (~full_q | (bus.out_ready & last));

   assign accept   = bus.in_valid & bus.in_ready;
   assign slice_hs = full_q & bus.out_ready;

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      idx_d   = idx_q;
      order_d = order_q;
      // A new word wins over the retiring last slice, so the pipe never drains.
      if (accept) begin
         state_d = SEND;
         word_d  = bus.in_data;
         order_d = bus.msb_first;
         idx_d   = '0;
      end else if (slice_hs) begin
         if (last) begin
            state_d = EMPTY;
            idx_d   = '0;
         end else begin
            idx_d = idx_q + IDX_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= EMPTY;
         word_q  <= '0;
         idx_q   <= '0;
         order_q <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         idx_q   <= idx_d;
         order_q <= order_d;
      end
   end
endmodule

// File: tb/tb_cfs_fifo_unpacker.sv
// Self-checking bench: table of single words with expected slices, hand sequences for
// back-to-back, backpressure, order toggle and mid-word reset, plus a random 8/8 run.
module tb_cfs_fifo_unpacker;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   cfs_fifo_unpacker_if #(.IN_WIDTH(32), .OUT_WIDTH(8)) b ();
   cfs_fifo_unpacker_if #(.IN_WIDTH(8),  .OUT_WIDTH(8)) b8 ();

   cfs_fifo_unpacker #(.IN_WIDTH(32), .OUT_WIDTH(8)) dut   (.clk(clk), .reset_n(reset_n), .bus(b));
   cfs_fifo_unpacker #(.IN_WIDTH(8),  .OUT_WIDTH(8)) dut8  (.clk(clk), .reset_n(reset_n), .bus(b8));

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_slice(logic [31:0] w, logic m, int i);
      int k;
      k = m ? 3 - i : i;
      return w[k*8 +: 8];
   endfunction

   // Scoreboard for the 32->8 instance: {last, data} per slice, pushed on accept.
   logic [8:0] sbq[$];
   logic [8:0] e9;
   always @(negedge clk) begin
      if (!reset_n) begin
         chk("in_ready_in_reset", b.in_ready, 1'b0);
         sbq.delete();
      end else begin
         if (b.out_valid && b.out_ready) begin
            if (sbq.size() == 0) chk("sb_underflow", 1, 0);
            else begin
               e9 = sbq.pop_front();
               chk("sb_data", b.out_data, e9[7:0]);
               chk("sb_last", b.out_last, e9[8]);
            end
         end
         if (b.in_valid && b.in_ready)
            for (int i = 0; i < 4; i++) sbq.push_back({i == 3, ref_slice(b.in_data, b.msb_first, i)});
      end
   end

   // Scoreboard for the 8->8 instance: plain reference queue of accepted bytes.
   logic [7:0] q8[$];
   logic [7:0] e8;
   int n_in8 = 0, n_out8 = 0;
   always @(negedge clk) begin
      if (!reset_n) q8.delete();
      else begin
         if (b8.out_valid && b8.out_ready) begin
            n_out8++;
            if (q8.size() == 0) chk("sb8_underflow", 1, 0);
            else begin
               e8 = q8.pop_front();
               chk("sb8_data", b8.out_data, e8);
               chk("sb8_last", b8.out_last, 1'b1);
            end
         end
         if (b8.in_valid && b8.in_ready) begin
            q8.push_back(b8.in_data);
            n_in8++;
         end
      end
   end

   task automatic push_word(input logic [31:0] d, input logic m);
      bit ok = 0;
      b.in_valid = 1'b1; b.in_data = d; b.msb_first = m;
      for (int n = 0; n < 50 && !ok; n++) begin
         @(negedge clk);
         if (b.in_ready) ok = 1;
      end
      if (!ok) chk("push_timeout", 0, 1);
      @(posedge clk); #1;
      b.in_valid = 1'b0;
   endtask

   task automatic tick;
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [31:0]      data;
      logic             msb;
      logic [3:0][7:0]  exp;   // exp[0] is the first slice out
   } vec_t;
   vec_t vecs[7];

   initial begin
      int rdy_cnt;
      logic [7:0] b2b[8];
      bit a;

      vecs[0] = '{32'h44332211, 1'b0, {8'h44, 8'h33, 8'h22, 8'h11}};
      vecs[1] = '{32'h44332211, 1'b1, {8'h11, 8'h22, 8'h33, 8'h44}};
      vecs[2] = '{32'hDEADBEEF, 1'b0, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
      vecs[3] = '{32'hDEADBEEF, 1'b1, {8'hEF, 8'hBE, 8'hAD, 8'hDE}};
      vecs[4] = '{32'h00000000, 1'b0, {8'h00, 8'h00, 8'h00, 8'h00}};
      vecs[5] = '{32'h80000001, 1'b0, {8'h80, 8'h00, 8'h00, 8'h01}};
      vecs[6] = '{32'h80000001, 1'b1, {8'h01, 8'h00, 8'h00, 8'h80}};

      b.in_valid = 0; b.in_data = '0; b.msb_first = 0; b.out_ready = 1;
      b8.in_valid = 0; b8.in_data = '0; b8.msb_first = 0; b8.out_ready = 1;

      // Reset state
      tick; tick;
      @(negedge clk);
      chk("rst_out_valid", b.out_valid, 0);
      chk("rst_out_data",  b.out_data, 0);
      chk("rst_out_last",  b.out_last, 0);
      chk("rst_busy",      b.busy, 0);
      chk("rst_out_valid8", b8.out_valid, 0);
      tick; reset_n = 1'b1;

      // Table: one word at a time, out_ready high, latency 1 and idle afterwards
      foreach (vecs[v]) begin
         push_word(vecs[v].data, vecs[v].msb);
         for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("vec%0d_valid%0d", v, i), b.out_valid, 1);
            chk($sformatf("vec%0d_busy%0d", v, i), b.busy, 1);
            chk($sformatf("vec%0d_data%0d", v, i), b.out_data, vecs[v].exp[i]);
            chk($sformatf("vec%0d_last%0d", v, i), b.out_last, i == 3);
            chk($sformatf("vec%0d_inrdy%0d", v, i), b.in_ready, i == 3);
         end
         @(negedge clk);
         chk($sformatf("vec%0d_idle_valid", v), b.out_valid, 0);
         chk($sformatf("vec%0d_idle_data", v), b.out_data, 0);
      end

      // Back-to-back words with in_valid held high
      b2b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h55, 8'h66, 8'h77, 8'h88};
      tick;
      b.in_valid = 1; b.in_data = 32'hDDCCBBAA; b.msb_first = 0;
      @(negedge clk); chk("b2b_first_rdy", b.in_ready, 1);
      tick; b.in_data = 32'h88776655;
      rdy_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("b2b_valid%0d", k), b.out_valid, 1);
         chk($sformatf("b2b_data%0d", k), b.out_data, b2b[k]);
         if (b.in_ready) rdy_cnt++;
         tick;
         if (k == 3) b.in_valid = 0;
      end
      chk("b2b_inrdy_count", rdy_cnt, 2);
      @(negedge clk); chk("b2b_idle", b.out_valid, 0);

      // Backpressure on slice 0x22
      push_word(32'h44332211, 0);
      @(negedge clk); chk("bp_s0", b.out_data, 8'h11);
      tick; b.out_ready = 0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("bp_hold_data%0d", k), b.out_data, 8'h22);
         chk($sformatf("bp_hold_valid%0d", k), b.out_valid, 1);
         chk($sformatf("bp_hold_inrdy%0d", k), b.in_ready, 0);
         tick;
      end
      b.out_ready = 1;
      @(negedge clk); chk("bp_release", b.out_data, 8'h22);
      tick; @(negedge clk); chk("bp_resume", b.out_data, 8'h33);
      tick; @(negedge clk); chk("bp_tail", b.out_data, 8'h44);
      chk("bp_tail_last", b.out_last, 1);
      tick;

      // msb_first toggled while the word is held
      push_word(32'h44332211, 1);
      for (int i = 0; i < 4; i++) begin
         b.msb_first = ~b.msb_first;
         @(negedge clk);
         chk($sformatf("ord_data%0d", i), b.out_data, ref_slice(32'h44332211, 1'b1, i));
         tick;
      end

      // Reset after two slices
      push_word(32'h44332211, 0);
      @(negedge clk); chk("rmw_s0", b.out_data, 8'h11);
      tick; @(negedge clk); chk("rmw_s1", b.out_data, 8'h22);
      tick; reset_n = 0;
      @(negedge clk); chk("rmw_inrdy_low", b.in_ready, 0);
      tick; reset_n = 1;
      @(negedge clk);
      chk("rmw_valid", b.out_valid, 0);
      chk("rmw_last",  b.out_last, 0);
      chk("rmw_data",  b.out_data, 0);
      push_word(32'h0A0B0C0D, 0);
      @(negedge clk); chk("rmw_next_s0", b.out_data, 8'h0D);
      for (int i = 0; i < 4; i++) tick;

      // Random bytes through the 8/8 instance
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         a = b8.in_valid && b8.in_ready;
         tick;
         if (!b8.in_valid || a) begin
            b8.in_valid = 1'($urandom_range(0, 1));
            b8.in_data  = 8'($urandom);
         end
         b8.out_ready = 1'($urandom_range(0, 1));
      end
      b8.out_ready = 1;
      for (int c = 0; c < 10 && b8.in_valid; c++) begin
         @(negedge clk);
         a = b8.in_valid && b8.in_ready;
         tick;
         if (a) b8.in_valid = 0;
      end
      chk("r8_in_dropped", b8.in_valid, 0);
      for (int c = 0; c < 5; c++) tick;
      chk("r8_queue_empty", q8.size(), 0);
      chk("r8_count", n_out8, n_in8);
      chk("r8_nonzero", n_in8 > 20, 1);
      chk("sb_queue_empty", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
endmodule
